mini_core_accel_mul_int8: RTL and testbench
===========================================

# mini_core_accel_mul_int8

Sequential signed 8x8 multiplier. It is the accelerator-farm leaf that consumes the operand pairs driven out of the accelerator CR memory and returns `{done, result}` to it. It detects a new operand pair and runs an 8-step radix-2 Booth iteration. It presents a 16-bit signed product with a sticky `done` flag that the core polls through the CR space. The accelerator farm instantiates eight copies, indices 0..7.

## Interface
Parameters:
- None. Widths are fixed by the package types: 8-bit signed operands and a 16-bit signed result.

Ports:
- `Clk`  in  1  — single clock; all state is on its rising edge.
- `Rst_N`  in  1  — reset, asynchronous and active-low.
- `core2mul`  in  `t_core2mul_int8`  — `multiplicand[7:0]` and `multiplier[7:0]`, signed, level-held by the CR flops.
- `mul2core`  out  `t_mul2core_int8`  — `result[15:0]` (signed product) and `done` (1 = `result` matches the currently captured operands).

## Operation
- Internal registers:
  - `cap_mcand`, `cap_mplier` (8b): captured operands.
  - `state`: `IDLE` or `BUSY`.
  - `cnt` (3b).
  - Booth accumulator `A` (9b), `Q` (8b), `q_m1` (1b).
  - `M` (9b): multiplicand sign-extended to 9 bits.
  - `result` (16b), `done` (1b).
- Reset values:
  - `state=IDLE`, `cnt=0`, `cap_*=0`, `A=0`, `Q=0`, `q_m1=0`, `M=0`.
  - `result=16'h0000`, `done=1`. This is consistent because 0*0=0, so a core that writes zero operands is never left polling forever.
- Change detect: `new_op = {core2mul.multiplicand, core2mul.multiplier} != {cap_mcand, cap_mplier}`.
- `IDLE`:
  - If `new_op`: capture the operands; load `M=sext(mcand)`, `A=0`, `Q=mplier`, `q_m1=0`, `cnt=0`.
  - In the same edge: `done<=0`, go to `BUSY`.
  - Otherwise hold. `result` and `done` are unchanged.
- `BUSY`, one Booth step per cycle:
  - Select on `{Q[0],q_m1}`: `01` → `A+M`; `10` → `A-M`; `00`/`11` → `A`. Call the selected value `A'`.
  - Arithmetic right shift of `{A',Q,q_m1}` by 1. The 9-bit `A` avoids overflow for `M=-128`.
  - `cnt++`.
  - On the step with `cnt==7`: `result <= {A_next[7:0], Q_next}`, `done<=1`, go to `IDLE`.
- Operand change during `BUSY` (`new_op`): the current job is aborted. On the same edge the new operands are captured and the datapath is reloaded (`cnt=0`), the state stays `BUSY` and `done` stays 0. The reported result therefore always corresponds to the latest operands.
- Rewriting identical operands is not a new job: no restart, and `done` stays 1.
- `result` is updated only on completion. During `BUSY` it holds the previous product while `done=0`.

## Timing
- Operand change visible after edge E0:
  - E1: capture, `done=0`.
  - E2..E9: eight Booth steps.
  - E9: `result` valid, `done=1`.
- Latency is 9 cycles from operand change to `done` high. No back-to-back throughput is required.
- `result` and `done` are driven straight from flops with no combinational path from `core2mul`.
- Core-visible latency adds CR-memory sampling and its read register. The core polls `done` and must not rely on a cycle count.
- Reset assertion mid-`BUSY` immediately (asynchronously) forces the reset values. After release the block sits in `IDLE` until the operands differ from 0/0.
- Operands changing on consecutive cycles: each change restarts; completion occurs 9 cycles after the last change.

## Structure
- `mini_core_accel_pkg` owns:
  - `t_core2mul_int8` `{logic [7:0] multiplicand; logic [7:0] multiplier;}`.
  - `t_mul2core_int8` `{logic done; logic [15:0] result;}`.
  - `MUL_INT8_STEPS = 8`.
  - `t_mul_int8_state` enum `{MUL_IDLE, MUL_BUSY}`.
  - `NUM_MUL_INT8 = 8`.
- Flops use the team's async active-low reset DFF macro.
- No sub-module is needed. The Booth step is a local combinational block. The farm wrapper `mini_core_accel_farm` instantiates `NUM_MUL_INT8` copies in a generate loop.

## Test plan
- Reset, then hold operands 0/0 → `done=1`, `result=0x0000`, no `BUSY` for 20 cycles.
- Operands 3 and 5 → `done` low at E1, high at E9, `result=0x000F`.
- Operands -128 and -128 (0x80, 0x80) → `result=0x4000`; also -1 and 127 → `result=0xFF81`; also -128 and 127 → `result=0xC080`.
- Operands 7 and 9, then at E4 change to -6 and 11 → `done` stays 0 until 9 cycles after the change, `result=0xFFBE`, and 0x003F is never flagged done.
- Operands 12 and 12, then `Rst_N` low at E5 → immediately `done=1`, `result=0`; after release, `IDLE` until the operands differ from 0/0.
- After 4*4 completes, rewrite 4/4 → no restart, `done` stays 1, `result=0x0010`.

Source files
------------

// File: rtl/mini_core_accel_pkg.sv
// Shared types and constants for the accelerator-farm int8 multiplier leaves.
package mini_core_accel_pkg;

  typedef struct packed {
    logic [7:0] multiplicand;
    logic [7:0] multiplier;
  } t_core2mul_int8;

  typedef struct packed {
    logic        done;
    logic [15:0] result;
  } t_mul2core_int8;

  typedef enum logic {
    MUL_IDLE,
    MUL_BUSY
  } t_mul_int8_state;

  localparam int unsigned MUL_INT8_STEPS = 8;
  localparam int unsigned NUM_MUL_INT8   = 8;

endpackage

// File: rtl/mini_core_accel_mul_int8.sv
// Sequential signed 8x8 radix-2 Booth multiplier; restarts whenever the held
// operands change and reports a sticky done with the latest product.
module mini_core_accel_mul_int8
  import mini_core_accel_pkg::*;
(
  input  logic           Clk,
  input  logic           Rst_N,
  input  t_core2mul_int8 core2mul,
  output t_mul2core_int8 mul2core
);

  localparam logic [2:0] LAST_STEP = 3'(MUL_INT8_STEPS - 1);

  t_mul_int8_state state;
  logic [2:0]      cnt;
  logic [7:0]      cap_mcand;
  logic [7:0]      cap_mplier;
  logic [8:0]      a_reg;
  logic [7:0]      q_reg;
  logic            q_m1;
  logic [8:0]      m_reg;
  logic [15:0]     result_q;
  logic            done_q;

  logic            new_op;
  logic [8:0]      a_sel;
  logic [8:0]      a_next;
  logic [7:0]      q_next;
  logic            q_m1_next;

  assign new_op = {core2mul.multiplicand, core2mul.multiplier} != {cap_mcand, cap_mplier};

  // One Booth step: add/subtract M, then arithmetic shift of {A', Q, q_m1}.
  always_comb begin
    a_sel = a_reg;
    case ({q_reg[0], q_m1})
      2'b01:   a_sel = a_reg + m_reg;
      2'b10:   a_sel = a_reg - m_reg;
      default: a_sel = a_reg;
    endcase
    a_next    = {a_sel[8], a_sel[8:1]};
    q_next    = {a_sel[0], q_reg[7:1]};
    q_m1_next = q_reg[0];
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state      <= MUL_IDLE;
      cnt        <= '0;
      cap_mcand  <= '0;
      cap_mplier <= '0;
      a_reg      <= '0;
      q_reg      <= '0;
      q_m1       <= 1'b0;
      m_reg      <= '0;
      result_q   <= '0;
      done_q     <= 1'b1;
    end else if (new_op) begin
      // Same load path serves a fresh job from IDLE and an abort from BUSY.
      cap_mcand  <= core2mul.multiplicand;
      cap_mplier <= core2mul.multiplier;
      m_reg      <= {core2mul.multiplicand[7], core2mul.multiplicand};
      a_reg      <= '0;
      q_reg      <= core2mul.multiplier;
      q_m1       <= 1'b0;
      cnt        <= '0;
      done_q     <= 1'b0;
      state      <= MUL_BUSY;
    end else if (state == MUL_BUSY) begin
      a_reg <= a_next;
      q_reg <= q_next;
      q_m1  <= q_m1_next;
      cnt   <= cnt + 3'd1;
      if (cnt == LAST_STEP) begin
        result_q <= {a_next[7:0], q_next};
        done_q   <= 1'b1;
        state    <= MUL_IDLE;
      end
    end
  end

  assign mul2core.done   = done_q;
  assign mul2core.result = result_q;

endmodule

// File: tb/tb_mini_core_accel_mul_int8.sv
// Scoreboard bench for the int8 Booth multiplier: expected products are queued
// when operands are driven and checked when done rises.
module tb_mini_core_accel_mul_int8;
  import mini_core_accel_pkg::*;

  logic           Clk;
  logic           Rst_N;
  t_core2mul_int8 core2mul;
  t_mul2core_int8 mul2core;

  int tests_run;
  int tests_failed;
  logic [15:0] sb[$];

  mini_core_accel_mul_int8 dut (
    .Clk      (Clk),
    .Rst_N    (Rst_N),
    .core2mul (core2mul),
    .mul2core (mul2core)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    core2mul.multiplicand = a;
    core2mul.multiplier   = b;
  endtask

  // Drive a new job, wait (bounded) for done, check latency and popped result.
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input string name);
    int lat;
    logic [15:0] exp;
    drive(a, b);
    sb.push_back(model_mul(a, b));
    lat = 0;
    do begin
      tick();
      lat++;
    end while (mul2core.done !== 1'b1 && lat < 20);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d cycles, expected 9", name, lat);
    end
    exp = sb.pop_front();
    tests_run++;
    if (mul2core.result !== exp) begin
      tests_failed++;
      $display("FAIL %s_result: got %h expected %h", name, mul2core.result, exp);
    end
  endtask

  task automatic test_reset();
    Rst_N = 1'b0;
    drive(8'h00, 8'h00);
    repeat (3) tick();
    tests_run++;
    if (mul2core.done !== 1'b1 || mul2core.result !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_values: got done=%b result=%h expected done=1 result=0000",
               mul2core.done, mul2core.result);
    end
    Rst_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (mul2core.done !== 1'b1 || mul2core.result !== 16'h0000) begin
        tests_failed++;
        $display("FAIL idle_zero_ops c%0d: got done=%b result=%h expected done=1 result=0000",
                 i, mul2core.done, mul2core.result);
      end
    end
  endtask

  task automatic test_basic();
    drive(8'd3, 8'd5);
    sb.push_back(model_mul(8'd3, 8'd5));
    for (int e = 1; e <= 9; e++) begin
      tick();
      tests_run++;
      if (mul2core.done !== (e == 9)) begin
        tests_failed++;
        $display("FAIL basic_done_E%0d: got %b expected %b", e, mul2core.done, e == 9);
      end
      if (e < 9) begin
        tests_run++;
        if (mul2core.result !== 16'h0000) begin
          tests_failed++;
          $display("FAIL basic_result_hold_E%0d: got %h expected 0000", e, mul2core.result);
        end
      end
    end
    tests_run++;
    if (mul2core.result !== sb.pop_front() || mul2core.result !== 16'h000F) begin
      tests_failed++;
      $display("FAIL basic_result: got %h expected 000f", mul2core.result);
    end
  endtask

  task automatic test_corners();
    run_job(8'h80, 8'h80, "m128_m128");
    tests_run++;
    if (mul2core.result !== 16'h4000) begin
      tests_failed++;
      $display("FAIL m128_m128_const: got %h expected 4000", mul2core.result);
    end
    run_job(8'hFF, 8'h7F, "m1_127");
    tests_run++;
    if (mul2core.result !== 16'hFF81) begin
      tests_failed++;
      $display("FAIL m1_127_const: got %h expected ff81", mul2core.result);
    end
    run_job(8'h80, 8'h7F, "m128_127");
    tests_run++;
    if (mul2core.result !== 16'hC080) begin
      tests_failed++;
      $display("FAIL m128_127_const: got %h expected c080", mul2core.result);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ({a, b} == {core2mul.multiplicand, core2mul.multiplier}) b = b ^ 8'h01;
      run_job(a, b, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [15:0] exp;
    drive(8'd7, 8'd9);
    sb.push_back(model_mul(8'd7, 8'd9));
    for (int e = 1; e <= 4; e++) begin
      tick();
      tests_run++;
      if (mul2core.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_pre_E%0d: got done=%b result=%h expected done=0",
                 e, mul2core.done, mul2core.result);
      end
    end
    void'(sb.pop_back());
    drive(8'hFA, 8'd11);
    sb.push_back(model_mul(8'hFA, 8'd11));
    lat = 0;
    do begin
      tick();
      lat++;
      if (mul2core.done === 1'b1 && mul2core.result === 16'h003F) begin
        tests_run++;
        tests_failed++;
        $display("FAIL abort_stale_flagged: got 003f with done=1, expected ffbe");
      end
    end while (mul2core.done !== 1'b1 && lat < 20);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("FAIL abort_latency: got %0d cycles, expected 9", lat);
    end
    exp = sb.pop_front();
    tests_run++;
    if (mul2core.result !== exp || exp !== 16'hFFBE) begin
      tests_failed++;
      $display("FAIL abort_result: got %h expected ffbe", mul2core.result);
    end
  endtask

  task automatic test_reset_midbusy();
    drive(8'd12, 8'd12);
    sb.push_back(model_mul(8'd12, 8'd12));
    repeat (5) tick();
    Rst_N = 1'b0;
    #1;
    sb.delete();
    tests_run++;
    if (mul2core.done !== 1'b1 || mul2core.result !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midbusy_reset_async: got done=%b result=%h expected done=1 result=0000",
               mul2core.done, mul2core.result);
    end
    drive(8'h00, 8'h00);
    tick();
    Rst_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++;
      if (mul2core.done !== 1'b1 || mul2core.result !== 16'h0000) begin
        tests_failed++;
        $display("FAIL post_reset_idle c%0d: got done=%b result=%h expected done=1 result=0000",
                 i, mul2core.done, mul2core.result);
      end
    end
    run_job(8'd12, 8'd12, "post_reset_12x12");
  endtask

  task automatic test_rewrite();
    run_job(8'd4, 8'd4, "four_four");
    drive(8'd4, 8'd4);
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++;
      if (mul2core.done !== 1'b1 || mul2core.result !== 16'h0010) begin
        tests_failed++;
        $display("FAIL rewrite_same c%0d: got done=%b result=%h expected done=1 result=0010",
                 i, mul2core.done, mul2core.result);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] exp;
    drive(8'd20, 8'd3);
    sb.push_back(model_mul(8'd20, 8'd3));
    tick();
    void'(sb.pop_back());
    drive(8'hF0, 8'd5);
    sb.push_back(model_mul(8'hF0, 8'd5));
    tick();
    void'(sb.pop_back());
    drive(8'd9, 8'hF7);
    sb.push_back(model_mul(8'd9, 8'hF7));
    lat = 0;
    do begin
      tick();
      lat++;
    end while (mul2core.done !== 1'b1 && lat < 20);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d cycles, expected 9", lat);
    end
    exp = sb.pop_front();
    tests_run++;
    if (mul2core.result !== exp) begin
      tests_failed++;
      $display("FAIL b2b_result: got %h expected %h", mul2core.result, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Rst_N        = 1'b0;
    core2mul     = '0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_abort();
    test_reset_midbusy();
    test_rewrite();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
